// File: rtl/mul_seq_256b.sv
//------------------------------------------------------------------------------
// Module      : mul_seq_256b
// Description : Sequencer for a 256b x 256b -> 512b unsigned multiply built
//               from four 128b x 128b passes on one external multiplier using
//               a start-level / finish-pulse handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul_seq_256b #(
  parameter int VLD_CYC     = 3,
  parameter int FIN_TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_vld_i,
  output logic         req_rdy_o,
  input  logic [255:0] req_a_i,
  input  logic [255:0] req_b_i,
  output logic         res_vld_o,
  output logic [511:0] res_o,
  output logic         err_o,
  output logic         mul_vld_o,
  output logic [127:0] mul_a_o,
  output logic [127:0] mul_b_o,
  input  logic         mul_fin_i,
  input  logic [255:0] mul_r_i
);

  // Counter spans both the start-level phase and the finish wait of a pass.
  localparam int CW = $clog2(FIN_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [255:0]   a_q;
  logic [255:0]   b_q;
  logic [1:0]     k;
  logic [1:0]     k_nxt;
  logic [CW-1:0]  cnt;
  logic [511:0]   acc;
  logic           err;
  logic [511:0]   part;
  logic [511:0]   acc_sum;
  logic           accept;
  logic           issue_last;
  logic           fin_ok;
  logic           timeout;

  assign accept     = req_vld_i && (state == IDLE);
  assign issue_last = (state == ISSUE) && (cnt == CW'(VLD_CYC - 1));
  assign fin_ok     = (state == WAIT) && mul_fin_i;
  assign timeout    = (state == WAIT) && !mul_fin_i && (cnt >= CW'(FIN_TIMEOUT));
  assign k_nxt      = k + 2'd1;
  assign acc_sum    = acc + part;

  assign req_rdy_o  = (state == IDLE);
  assign mul_vld_o  = (state == ISSUE);
  assign res_vld_o  = (state == DONE);

  // Position the current partial product at its weight: 0, 128, 128, 256.
  always_comb begin
    part = '0;
    case (k)
      2'd0:    part = {256'd0, mul_r_i};
      2'd1,
      2'd2:    part = {128'd0, mul_r_i, 128'd0};
      default: part = {mul_r_i, 256'd0};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: finish wins over timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (issue_last) state_nxt = WAIT;
      WAIT: begin
        if (fin_ok)       state_nxt = (k == 2'd3) ? DONE : ISSUE;
        else if (timeout) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, pass counter, cycle counter, accumulator and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      k       <= '0;
      cnt     <= '0;
      acc     <= '0;
      err     <= 1'b0;
      res_o   <= '0;
      err_o   <= 1'b0;
      mul_a_o <= '0;
      mul_b_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= req_a_i;
            b_q     <= req_b_i;
            acc     <= '0;
            k       <= 2'd0;
            cnt     <= '0;
            err     <= 1'b0;
            mul_a_o <= req_a_i[127:0];
            mul_b_o <= req_b_i[127:0];
          end
        end
        ISSUE: cnt <= cnt + 1'b1;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (fin_ok) begin
            acc <= acc_sum;
            if (k == 2'd3) begin
              res_o <= acc_sum;
              err_o <= err;
            end else begin
              k       <= k_nxt;
              cnt     <= '0;
              // Pass index bit 1 picks the A half, bit 0 picks the B half.
              mul_a_o <= k_nxt[1] ? a_q[255:128] : a_q[127:0];
              mul_b_o <= k_nxt[0] ? b_q[255:128] : b_q[127:0];
            end
          end else if (timeout) begin
            err   <= 1'b1;
            res_o <= acc;
            err_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_256b.sv
//------------------------------------------------------------------------------
// Module      : tb_mul_seq_256b
// Description : Self-checking bench for mul_seq_256b with a behavioural
//               128b multiplier stub and a full-width product reference.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_seq_256b;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_vld = 1'b0;
  logic         req_rdy;
  logic [255:0] req_a = '0;
  logic [255:0] req_b = '0;
  logic         res_vld;
  logic [511:0] res;
  logic         err;
  logic         mul_vld;
  logic [127:0] mul_a;
  logic [127:0] mul_b;
  logic         mul_fin;
  logic [255:0] mul_r;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Stub behaviour controls.
  logic nofin = 1'b0;
  logic spur  = 1'b0;

  mul_seq_256b #(.VLD_CYC(3), .FIN_TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld_i (req_vld),
    .req_rdy_o (req_rdy),
    .req_a_i   (req_a),
    .req_b_i   (req_b),
    .res_vld_o (res_vld),
    .res_o     (res),
    .err_o     (err),
    .mul_vld_o (mul_vld),
    .mul_a_o   (mul_a),
    .mul_b_o   (mul_b),
    .mul_fin_i (mul_fin),
    .mul_r_i   (mul_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] ref_mul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] wa;
    logic [511:0] wb;
    wa = {256'd0, a};
    wb = {256'd0, b};
    return wa * wb;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Multiplier stub: answers 3 cycles after the start rise with the product of
  // the operands seen at the rise; optionally injects a junk fin during ISSUE.
  logic         vld_q;
  int           run;
  int           fcnt;
  logic [127:0] cap_a;
  logic [127:0] cap_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      run     <= 0;
      fcnt    <= 0;
      mul_fin <= 1'b0;
      mul_r   <= '0;
      cap_a   <= '0;
      cap_b   <= '0;
    end else begin
      vld_q   <= mul_vld;
      mul_fin <= 1'b0;
      run     <= mul_vld ? run + 1 : 0;
      if (!mul_vld && vld_q) chk("vld_high_len", 512'(run), 512'd3);
      if (mul_vld && !vld_q) begin
        cap_a <= mul_a;
        cap_b <= mul_b;
        fcnt  <= 1;
        if (spur) begin
          mul_fin <= 1'b1;
          mul_r   <= rnd256();
        end
      end else if (fcnt == 1) begin
        fcnt <= 2;
      end else if (fcnt == 2) begin
        fcnt <= 0;
        chk("op_a_stable", {384'd0, mul_a}, {384'd0, cap_a});
        chk("op_b_stable", {384'd0, mul_b}, {384'd0, cap_b});
        if (!nofin) begin
          mul_fin <= 1'b1;
          mul_r   <= {128'd0, cap_a} * {128'd0, cap_b};
        end
      end
    end
  end

  // One request: wait for ready, check result latency, product and error flag.
  // Called at a negative edge; returns at the negative edge of the result
  // (keep=1) or one cycle later after checking the result is held (keep=0).
  task automatic do_req(input logic [255:0] a, input logic [255:0] b, input int lat,
                        input logic exp_err, input logic keep, output int e);
    logic found;
    logic [511:0] exp;
    exp     = ref_mul(a, b);
    req_vld = 1'b1;
    req_a   = a;
    req_b   = b;
    for (int n = 0; n < 40 && !req_rdy; n++) @(negedge clk);
    chk("rdy_before_accept", {511'd0, req_rdy}, 512'd1);
    e = cyc + 1;
    @(negedge clk);
    if (!keep) req_vld = 1'b0;
    req_a = rnd256();
    req_b = rnd256();
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (res_vld) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("res_vld_seen", {511'd0, found}, 512'd1);
    chk("res_latency", 512'(cyc - e), 512'(lat));
    chk("err_o", {511'd0, err}, {511'd0, exp_err});
    if (!exp_err) chk("res_o", res, exp);
    if (!keep) begin
      @(negedge clk);
      chk("res_vld_pulse", {511'd0, res_vld}, 512'd0);
      if (!exp_err) chk("res_o_held", res, exp);
      chk("rdy_after_done", {511'd0, req_rdy}, 512'd1);
    end
  endtask

  initial begin
    int e;
    int prev_e;
    logic seen;
    logic [255:0] a;
    logic [255:0] b;
    logic [511:0] all1_exp;

    // Reset state.
    @(negedge clk);
    chk("rst_rdy", {511'd0, req_rdy}, 512'd1);
    chk("rst_res_vld", {511'd0, res_vld}, 512'd0);
    chk("rst_res", res, 512'd0);
    chk("rst_err", {511'd0, err}, 512'd0);
    chk("rst_mul_vld", {511'd0, mul_vld}, 512'd0);
    chk("rst_mul_ab", {256'd0, mul_a, mul_b}, 512'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed products.
    do_req(256'd1, 256'd1, 16, 1'b0, 1'b0, e);
    chk("one_times_one", res, 512'd1);
    a = '1;
    do_req(a, a, 16, 1'b0, 1'b0, e);
    all1_exp = {{63{4'hF}}, 4'hE, {63{4'h0}}, 4'h1};
    chk("all_ones_const", res, all1_exp);
    a = 256'd1 << 128;
    do_req(a, a, 16, 1'b0, 1'b0, e);
    chk("pow128_sq", res, 512'd1 << 256);
    a = 256'd1 << 255;
    do_req(a, 256'd3, 16, 1'b0, 1'b0, e);
    chk("pow255_x3", res, 512'd3 << 255);

    // Finish never arrives: abort after the timeout, then recover.
    nofin = 1'b1;
    do_req(rnd256(), rnd256(), 9, 1'b1, 1'b0, e);
    nofin = 1'b0;
    do_req(rnd256(), rnd256(), 16, 1'b0, 1'b0, e);

    // Asynchronous reset in the middle of pass 2.
    req_vld = 1'b1;
    req_a   = rnd256();
    req_b   = rnd256();
    for (int n = 0; n < 40 && !req_rdy; n++) @(negedge clk);
    @(negedge clk);
    req_vld = 1'b0;
    repeat (9) @(negedge clk);
    chk("pass2_vld_before_rst", {511'd0, mul_vld}, 512'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", {511'd0, req_rdy}, 512'd1);
    chk("arst_mul_vld", {511'd0, mul_vld}, 512'd0);
    chk("arst_mul_ab", {256'd0, mul_a, mul_b}, 512'd0);
    chk("arst_res", {res[510:0], err}, 512'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | res_vld;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      seen = seen | res_vld;
    end
    chk("no_res_after_rst", {511'd0, seen}, 512'd0);
    do_req(rnd256(), rnd256(), 16, 1'b0, 1'b0, e);

    // Back-to-back random requests with spurious finishes during ISSUE.
    spur   = 1'b1;
    prev_e = 0;
    for (int i = 0; i < 1000; i++) begin
      a = rnd256();
      b = rnd256();
      if (i % 4 == 0) a[255:128] = '1;
      if (i % 4 == 1) b[127:0] = '1;
      do_req(a, b, 16, 1'b0, 1'b1, e);
      if (i > 0) chk("b2b_spacing", 512'(e - prev_e), 512'd18);
      prev_e = e;
    end
    req_vld = 1'b0;
    spur    = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
